// File: rtl/hdr_parser_core.sv
`default_nettype none
// ============================================================================
// Module      : hdr_parser_core
// Description : Packet header parser for the reconfigurable switch pipeline.
//               Reads a descriptor word at byte address 0 (bits[7:0] = header
//               count N, clamped to NUM_HEADERS), then N header words at
//               4, 8, ... through a synchronous-SRAM memory port, and presents
//               them as one flat vector with ready_o flagging completion.
//               Optional macro PARSER_BSWAP_EN: byte-swap each captured
//               header word (network to host order); descriptor unswapped.
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_parser_core #(
   parameter int WORD_WIDTH  = 32,
   parameter int NUM_HEADERS = 8,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_i,
   output logic                              mem_ce_o,
   output logic                              mem_we_o,
   output logic [ADDR_W-1:0]                 mem_addr_o,
   output logic [3:0]                        mem_width_o,
   output logic [DATA_W-1:0]                 mem_data_o,
   input  logic [DATA_W-1:0]                 mem_data_i,
   output logic                              ready_o,
   output logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_o
);

   localparam int                c_CNT_W    = $clog2(NUM_HEADERS + 1);
   localparam logic [c_CNT_W-1:0] c_MAX_HDRS = c_CNT_W'(NUM_HEADERS);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQ_DESC = 3'd1,
      S_CAP_DESC = 3'd2,
      S_REQ_HDR  = 3'd3,
      S_CAP_HDR  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [c_CNT_W-1:0]     r_k;
   logic [c_CNT_W-1:0]     r_n;
   logic [c_CNT_W-1:0]     w_k_inc;
   logic [c_CNT_W-1:0]     w_n_clamp;
   logic [7:0]             w_desc_cnt;
   logic [ADDR_W-1:0]      w_hdr_addr;
   logic [WORD_WIDTH-1:0]  w_cap_word;
   logic [WORD_WIDTH-1:0]  r_hdr [NUM_HEADERS];
   logic                   r_ready;

   assign w_desc_cnt = mem_data_i[7:0];
   assign w_n_clamp  = (w_desc_cnt > 8'(NUM_HEADERS)) ? c_MAX_HDRS : c_CNT_W'(w_desc_cnt);
   assign w_k_inc    = r_k + c_CNT_W'(1);
   // Header k lives at byte address 4*(k+1); the descriptor occupies word 0.
   assign w_hdr_addr = {(ADDR_W-2)'(w_k_inc), 2'b00};

`ifdef PARSER_BSWAP_EN
   generate
      for (genvar b = 0; b < WORD_WIDTH/8; b++) begin : g_bswap
         assign w_cap_word[8*b +: 8] = mem_data_i[WORD_WIDTH-8-8*b +: 8];
      end
   endgenerate
`else
   assign w_cap_word = mem_data_i[WORD_WIDTH-1:0];
`endif

   // The parser never writes memory.
   assign mem_we_o   = 1'b0;
   assign mem_data_o = '0;
   assign ready_o    = r_ready;

   generate
      for (genvar i = 0; i < NUM_HEADERS; i++) begin : g_pack
         assign parsed_hdrs_o[i*WORD_WIDTH +: WORD_WIDTH] = r_hdr[i];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and memory-port control; read data is captured one cycle
   // after the request, so each CAP state holds the address of its REQ state.
   always_comb begin
      w_next      = r_state;
      mem_ce_o    = 1'b0;
      mem_addr_o  = '0;
      mem_width_o = 4'd0;
      case (r_state)
         S_IDLE:     if (start_i) w_next = S_REQ_DESC;
         S_REQ_DESC: begin
            mem_ce_o = 1'b1;
            w_next   = S_CAP_DESC;
         end
         S_CAP_DESC: begin
            mem_ce_o = 1'b1;
            w_next   = (w_n_clamp != '0) ? S_REQ_HDR : S_DONE;
         end
         S_REQ_HDR: begin
            mem_ce_o   = 1'b1;
            mem_addr_o = w_hdr_addr;
            w_next     = S_CAP_HDR;
         end
         S_CAP_HDR: begin
            mem_ce_o   = 1'b1;
            mem_addr_o = w_hdr_addr;
            w_next     = (w_k_inc == r_n) ? S_DONE : S_REQ_HDR;
         end
         S_DONE:     if (!start_i) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
      mem_width_o = mem_ce_o ? 4'd4 : 4'd0;
   end

   // Header capture, count tracking and the registered completion flag.
   // ready_o follows DONE by one cycle and drops together with the return
   // to IDLE, giving a start-to-ready latency of 3+2N edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_k     <= '0;
         r_n     <= '0;
         r_ready <= 1'b0;
         for (int i = 0; i < NUM_HEADERS; i++) r_hdr[i] <= '0;
      end else begin
         r_ready <= (r_state == S_DONE) && start_i;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  for (int i = 0; i < NUM_HEADERS; i++) r_hdr[i] <= '0;
               end
            end
            S_CAP_DESC: begin
               r_n <= w_n_clamp;
               r_k <= '0;
            end
            S_CAP_HDR: begin
               for (int i = 0; i < NUM_HEADERS; i++) begin
                  if (r_k == c_CNT_W'(i)) r_hdr[i] <= w_cap_word;
               end
               r_k <= w_k_inc;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hdr_parser_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdr_parser_core
// Description : Self-checking bench for hdr_parser_core. A synchronous SRAM
//               model serves packets; expected slots, latency and address set
//               are derived from the packet layout rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdr_parser_core;
   localparam int NH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          mem_ce_o, mem_we_o;
   logic [31:0]   mem_addr_o;
   logic [3:0]    mem_width_o;
   logic [31:0]   mem_data_o;
   logic [31:0]   mem_data_i;
   logic          ready_o;
   logic [32*NH-1:0] parsed_hdrs_o;

   always #5 clk = ~clk;

   hdr_parser_core #(.WORD_WIDTH(32), .NUM_HEADERS(NH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
      .ready_o(ready_o), .parsed_hdrs_o(parsed_hdrs_o)
   );

   // Synchronous SRAM model plus an access log and port-protocol monitor.
   logic [31:0] mem [0:63];
   logic [31:0] addr_log [0:4095];
   int          log_n    = 0;
   int          prot_err = 0;

   always @(posedge clk) begin
      if (mem_ce_o === 1'b1) begin
         mem_data_i <= mem[mem_addr_o[7:2]];
         if (log_n < 4096) addr_log[log_n] <= mem_addr_o;
         log_n <= log_n + 1;
         if (mem_we_o !== 1'b0 || mem_width_o !== 4'd4 || mem_data_o !== 32'h0 || mem_addr_o[1:0] !== 2'b00)
            prot_err <= prot_err + 1;
      end else if (mem_ce_o === 1'b0 && (mem_we_o !== 1'b0 || mem_width_o !== 4'd0)) begin
         prot_err <= prot_err + 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: header count, storage order.
   function automatic int model_n(input logic [31:0] desc);
      int n = int'(desc[7:0]);
      return (n > NH) ? NH : n;
   endfunction

   function automatic logic [31:0] host_order(input logic [31:0] w);
`ifdef PARSER_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [31:0] hdr_word(input logic [31:0] base, input int k);
      return base * 32'(k + 1);
   endfunction

   // Descriptor at word 0, header k at word k+1, poison words beyond.
   task automatic load_pkt(input logic [31:0] desc, input logic [31:0] base);
      mem[0] = desc;
      for (int k = 0; k < NH; k++) mem[k+1] = hdr_word(base, k);
      for (int k = NH + 1; k < 64; k++) mem[k] = 32'hBAD0_0000 | 32'(k);
   endtask

   task automatic do_parse(input logic [31:0] desc, input logic [31:0] base, input bit wiggle,
                           input int exp_lat, input int exp_max, input string tag);
      int          n, cyc, lat, first, maxa;
      bit          got, stray;
      logic [63:0] mask, exp_mask;
      logic [31:0] a;
      n = model_n(desc);
      load_pkt(desc, base);
      @(negedge clk);
      start_i = 1'b1;
      first   = log_n;
      cyc     = 0;
      got     = 1'b0;
      while (!got && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (ready_o === 1'b1) got = 1'b1;
         else if (wiggle) start_i = (cyc <= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      lat = got ? cyc - 1 : -1;
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      for (int i = 0; i < NH; i++)
         check($sformatf("%s.slot%0d", tag, i), 64'(parsed_hdrs_o[32*i +: 32]),
               64'((i < n) ? host_order(hdr_word(base, i)) : 32'h0));
      mask  = '0;
      maxa  = 0;
      stray = 1'b0;
      for (int j = first; j < log_n && j < 4096; j++) begin
         a = addr_log[j];
         if (a >= 32'd256) stray = 1'b1;
         else begin
            mask[a[7:2]] = 1'b1;
            if (int'(a) > maxa) maxa = int'(a);
         end
      end
      exp_mask = (64'd1 << (n + 1)) - 64'd1;
      check({tag, ".addr_set"}, mask, exp_mask);
      check({tag, ".addr_stray"}, 64'(stray), 64'd0);
      check({tag, ".max_addr"}, 64'(maxa), 64'(exp_max));
      check({tag, ".port_protocol"}, 64'(prot_err), 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      check({tag, ".ready_fall"}, 64'(ready_o), 64'd0);
      check({tag, ".ce_idle"}, 64'(mem_ce_o), 64'd0);
   endtask

   typedef struct {
      logic [31:0] desc;
      logic [31:0] base;
      int          exp_lat;
      int          exp_max;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [31:0] desc;
      int          n;

      vecs[0] = '{32'h0000_0003, 32'h1111_1111,  9, 12};
      vecs[1] = '{32'h0000_0001, 32'hDEAD_BEEF,  5,  4};
      vecs[2] = '{32'h0000_0000, 32'hAAAA_AAAA,  3,  0};
      vecs[3] = '{32'h0000_00FF, 32'h0102_0304, 19, 32};
      vecs[4] = '{32'h1234_5601, 32'h0BAD_F00D,  5,  4};
      vecs[5] = '{32'h0000_0008, 32'h1020_3040, 19, 32};
      vecs[6] = '{32'h0000_0009, 32'h7777_0001, 19, 32};
      vecs[7] = '{32'h0000_0007, 32'h0F0F_0F0F, 17, 28};

      rst     = 1'b1;
      start_i = 1'b0;
      load_pkt(32'h0, 32'h0);

      // Reset held for three cycles.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check($sformatf("reset%0d.ce", c), 64'(mem_ce_o), 64'd0);
         check($sformatf("reset%0d.ready", c), 64'(ready_o), 64'd0);
         check($sformatf("reset%0d.hdrs_nz", c), 64'(|parsed_hdrs_o), 64'd0);
         check($sformatf("reset%0d.addr", c), 64'(mem_addr_o), 64'd0);
         check($sformatf("reset%0d.width", c), 64'(mem_width_o), 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Table-driven parses; vector 1 follows vector 0 to exercise a restart.
      for (int v = 0; v < 8; v++)
         do_parse(vecs[v].desc, vecs[v].base, 1'b0, vecs[v].exp_lat, vecs[v].exp_max,
                  $sformatf("vec%0d", v));

      // Restart result spelled out explicitly.
      do_parse(32'h1, 32'hDEAD_BEEF, 1'b0, 5, 4, "restart");
`ifdef PARSER_BSWAP_EN
      check("restart.slot0_literal", 64'(parsed_hdrs_o[31:0]), 64'h0000_0000_EFBE_ADDE);
`else
      check("restart.slot0_literal", 64'(parsed_hdrs_o[31:0]), 64'h0000_0000_DEAD_BEEF);
`endif

      // start_i dropped mid-parse: the parse still completes.
      load_pkt(32'h2, 32'h5A5A_0001);
      @(negedge clk); start_i = 1'b1;
      @(posedge clk);
      @(negedge clk); start_i = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("drop.slot0", 64'(parsed_hdrs_o[31:0]), 64'(host_order(hdr_word(32'h5A5A_0001, 0))));
      check("drop.slot1", 64'(parsed_hdrs_o[63:32]), 64'(host_order(hdr_word(32'h5A5A_0001, 1))));
      check("drop.slot2", 64'(parsed_hdrs_o[95:64]), 64'd0);
      check("drop.ready", 64'(ready_o), 64'd0);
      check("drop.ce", 64'(mem_ce_o), 64'd0);

      // Reset during REQ_HDR for header 1 (header 0 already captured).
      load_pkt(32'h3, 32'h1111_1111);
      @(negedge clk); start_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("midrst.pre_slot0", 64'(parsed_hdrs_o[31:0]), 64'(host_order(32'h1111_1111)));
      check("midrst.pre_addr", 64'(mem_addr_o), 64'd8);
      check("midrst.pre_ce", 64'(mem_ce_o), 64'd1);
      @(negedge clk); rst = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      check("midrst.ce", 64'(mem_ce_o), 64'd0);
      check("midrst.ready", 64'(ready_o), 64'd0);
      check("midrst.hdrs_nz", 64'(|parsed_hdrs_o), 64'd0);
      check("midrst.addr", 64'(mem_addr_o), 64'd0);
      check("midrst.width", 64'(mem_width_o), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("midrst.idle_ce", 64'(mem_ce_o), 64'd0);

      // Randomized packets with start_i toggled during the busy phase.
      for (int r = 0; r < 25; r++) begin
         desc = $urandom;
         desc[7:0] = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 11));
         n = model_n(desc);
         do_parse(desc, $urandom, 1'b1, 3 + 2 * n, 4 * n, $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
